// File: rtl/fpga_bram_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpga_bram_pkg : shared types and sizes for the FPGA BRAM bus controller
// Rev 1.0
// ---------------------------------------------------------------------------
package fpga_bram_pkg;

   localparam int BUS_WIDTH  = 64;
   localparam int LINE_WIDTH = 256;
   localparam int BURST_LEN  = LINE_WIDTH / BUS_WIDTH;
   localparam int BEAT_IDX_W = $clog2(BURST_LEN);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ADDR       = 3'd1,
      WDATA      = 3'd2,
      WAIT_WRESP = 3'd3,
      RDATA      = 3'd4,
      DONE       = 3'd5
   } fpga_bram_state_t;

   // Line-aligned address word as it appears on the multiplexed bus.
   function automatic logic [BUS_WIDTH-1:0] line_addr_word(input logic [31:0] addr);
      return {{(BUS_WIDTH-32){1'b0}}, addr[31:5], 5'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpga_bram_line_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpga_bram_line_buffer : 4x64 read-beat storage plus write-line beat select
// Rev 1.0
// ---------------------------------------------------------------------------
module fpga_bram_line_buffer
   import fpga_bram_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic                  wr_en,
   input  logic [BEAT_IDX_W-1:0] wr_idx,
   input  logic [BUS_WIDTH-1:0]  wr_data,
   input  logic [LINE_WIDTH-1:0] wdata_line,
   input  logic [BEAT_IDX_W-1:0] rd_idx,
   output logic [BUS_WIDTH-1:0]  rd_data,
   output logic [LINE_WIDTH-1:0] line
);

   logic [BURST_LEN-1:0][BUS_WIDTH-1:0] beats_q, beats_d;
   logic [BURST_LEN-1:0][BUS_WIDTH-1:0] wbeats;

   always_comb begin
      beats_d = beats_q;
      if (clr) begin
         beats_d = '0;
      end else if (wr_en) begin
         beats_d[wr_idx] = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beats_q <= '0;
      end else begin
         beats_q <= beats_d;
      end
   end

   assign wbeats  = wdata_line;
   assign rd_data = wbeats[rd_idx];
   assign line    = beats_q;

endmodule
`default_nettype wire

// File: rtl/fpga_bram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpga_bram_ctrl : cache-line master for the multiplexed FPGA BRAM bus
// Rev 1.0
// ---------------------------------------------------------------------------
module fpga_bram_ctrl
   import fpga_bram_pkg::*;
#(
   parameter int ADDRESS_DATA_WIDTH = BUS_WIDTH,
   parameter int TIMEOUT_CYCLES     = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [31:0]                   dfp_addr,
   input  logic                          dfp_read,
   input  logic                          dfp_write,
   input  logic [LINE_WIDTH-1:0]         dfp_wdata,
   output logic [LINE_WIDTH-1:0]         dfp_rdata,
   output logic                          dfp_resp,
   output logic [ADDRESS_DATA_WIDTH-1:0] address_data_bus_i,
   output logic                          address_on_i,
   output logic                          data_on_i,
   output logic                          read_en_i,
   output logic                          write_en_i,
   input  logic [ADDRESS_DATA_WIDTH-1:0] address_data_bus_o,
   input  logic                          resp_o,
   output logic                          error_o
);

   // Counts wait cycles 0..TIMEOUT_CYCLES-1; TIMEOUT_CYCLES must be >= 2.
   localparam int                  TMO_W     = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BEAT_IDX_W-1:0] BEAT_LAST = BEAT_IDX_W'(BURST_LEN - 1);

   fpga_bram_state_t state_q, state_d;
   logic                          is_write_q, is_write_d;
   logic [BEAT_IDX_W-1:0]         beat_q, beat_d;
   logic [TMO_W-1:0]              tmo_q, tmo_d;
   logic                          error_q, error_d;
   logic                          dfp_resp_q, dfp_resp_d;
   logic [ADDRESS_DATA_WIDTH-1:0] bus_q, bus_d;
   logic                          address_on_q, address_on_d;
   logic                          data_on_q, data_on_d;
   logic                          read_en_q, read_en_d;
   logic                          write_en_q, write_en_d;

   logic                          buf_clr;
   logic                          beat_acc;
   logic                          timeout;
   logic                          conflict;
   logic                          spurious;
   logic [BUS_WIDTH-1:0]          wbeat;
   logic                          addr_lsb_unused;

   assign addr_lsb_unused = ^dfp_addr[4:0];

   fpga_bram_line_buffer u_line_buffer (
      .clk        (clk),
      .rst        (rst),
      .clr        (buf_clr),
      .wr_en      (beat_acc),
      .wr_idx     (beat_q),
      .wr_data    (address_data_bus_o),
      .wdata_line (dfp_wdata),
      .rd_idx     (beat_d),
      .rd_data    (wbeat),
      .line       (dfp_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         is_write_q   <= 1'b0;
         beat_q       <= '0;
         tmo_q        <= '0;
         error_q      <= 1'b0;
         dfp_resp_q   <= 1'b0;
         bus_q        <= '0;
         address_on_q <= 1'b0;
         data_on_q    <= 1'b0;
         read_en_q    <= 1'b0;
         write_en_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         is_write_q   <= is_write_d;
         beat_q       <= beat_d;
         tmo_q        <= tmo_d;
         error_q      <= error_d;
         dfp_resp_q   <= dfp_resp_d;
         bus_q        <= bus_d;
         address_on_q <= address_on_d;
         data_on_q    <= data_on_d;
         read_en_q    <= read_en_d;
         write_en_q   <= write_en_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      is_write_d = is_write_q;
      beat_d     = beat_q;
      tmo_d      = '0;
      buf_clr    = 1'b0;
      beat_acc   = 1'b0;
      timeout    = 1'b0;
      conflict   = 1'b0;
      case (state_q)
         IDLE: begin
            if (dfp_read || dfp_write) begin
               buf_clr    = 1'b1;
               beat_d     = '0;
               is_write_d = dfp_write;
               if (dfp_read && dfp_write) begin
                  conflict = 1'b1;
                  state_d  = DONE;
               end else begin
                  state_d  = ADDR;
               end
            end
         end
         ADDR: state_d = is_write_q ? WDATA : RDATA;
         WDATA: begin
            if (beat_q == BEAT_LAST) begin
               state_d = WAIT_WRESP;
            end else begin
               beat_d = beat_q + 1'b1;
            end
         end
         WAIT_WRESP: begin
            if (resp_o) begin
               state_d = DONE;
            end else if (tmo_q == TMO_LAST) begin
               timeout = 1'b1;
               state_d = DONE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         RDATA: begin
            // An accepted beat restarts the wait window.
            if (resp_o) begin
               beat_acc = 1'b1;
               if (beat_q == BEAT_LAST) begin
                  state_d = DONE;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
            end else if (tmo_q == TMO_LAST) begin
               timeout = 1'b1;
               state_d = DONE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign spurious = resp_o && (state_q != WAIT_WRESP) && (state_q != RDATA);
   assign error_d  = error_q | conflict | timeout | spurious;

   // Outputs are decoded from the upcoming state so they appear registered.
   always_comb begin
      bus_d        = '0;
      address_on_d = 1'b0;
      data_on_d    = 1'b0;
      read_en_d    = 1'b0;
      write_en_d   = 1'b0;
      dfp_resp_d   = 1'b0;
      case (state_d)
         ADDR: begin
            address_on_d = 1'b1;
            bus_d        = line_addr_word(dfp_addr);
            read_en_d    = !is_write_d;
            write_en_d   = is_write_d;
         end
         WDATA: begin
            data_on_d  = 1'b1;
            write_en_d = 1'b1;
            bus_d      = wbeat;
         end
         DONE:    dfp_resp_d = 1'b1;
         default: ;
      endcase
   end

   assign address_data_bus_i = bus_q;
   assign address_on_i       = address_on_q;
   assign data_on_i          = data_on_q;
   assign read_en_i          = read_en_q;
   assign write_en_i         = write_en_q;
   assign dfp_resp           = dfp_resp_q;
   assign error_o            = error_q;

endmodule
`default_nettype wire

// File: tb/tb_fpga_bram_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fpga_bram_ctrl : randomized bench for fpga_bram_ctrl with a cycle model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fpga_bram_ctrl;

   localparam int TMO = 1024;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  dfp_addr;
   logic         dfp_read;
   logic         dfp_write;
   logic [255:0] dfp_wdata;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;
   logic [63:0]  address_data_bus_i;
   logic         address_on_i;
   logic         data_on_i;
   logic         read_en_i;
   logic         write_en_i;
   logic [63:0]  address_data_bus_o;
   logic         resp_o;
   logic         error_o;

   int n_tests = 0;
   int n_fail  = 0;

   bit          resp_at [0:2047];
   logic [63:0] rd_beat [4];

   always #5 clk = ~clk;

   fpga_bram_ctrl #(
      .ADDRESS_DATA_WIDTH (64),
      .TIMEOUT_CYCLES     (TMO)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .dfp_addr           (dfp_addr),
      .dfp_read           (dfp_read),
      .dfp_write          (dfp_write),
      .dfp_wdata          (dfp_wdata),
      .dfp_rdata          (dfp_rdata),
      .dfp_resp           (dfp_resp),
      .address_data_bus_i (address_data_bus_i),
      .address_on_i       (address_on_i),
      .data_on_i          (data_on_i),
      .read_en_i          (read_en_i),
      .write_en_i         (write_en_i),
      .address_data_bus_o (address_data_bus_o),
      .resp_o             (resp_o),
      .error_o            (error_o)
   );

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   task automatic clear_sched();
      foreach (resp_at[i]) resp_at[i] = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, " ctrl"}, {address_on_i, data_on_i, read_en_i, write_en_i, dfp_resp}, 5'b0);
      check_val({tag, " bus"}, address_data_bus_i, 64'h0);
   endtask

   // Starts at a negedge (cycle 0); resp_at/rd_beat describe the memory's behaviour.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [255:0] wline,
                          input logic exp_err, input string nm);
      int           done_c;
      int           last;
      int           nb;
      int           given;
      logic [255:0] exp_line;
      logic [4:0]   exp_ctrl;
      logic [63:0]  exp_bus;
      exp_line = '0;
      nb       = 0;
      done_c   = -1;
      last     = wr ? 5 : 1;
      for (int c = last + 1; c < 2040; c++) begin
         if (resp_at[c]) begin
            if (wr) begin
               done_c = c + 1;
               break;
            end
            exp_line[nb*64 +: 64] = rd_beat[nb];
            nb++;
            last = c;
            if (nb == 4) begin
               done_c = c + 1;
               break;
            end
         end else if (c - last >= TMO) begin
            done_c = c + 1;
            break;
         end
      end
      if (done_c < 0) begin
         $display("FAIL %s: schedule has no completion", nm);
         $fatal(1);
      end

      dfp_addr  = addr;
      dfp_wdata = wline;
      dfp_read  = !wr;
      dfp_write = wr;
      resp_o    = 1'b0;
      given     = 0;
      for (int c = 1; c <= done_c; c++) begin
         @(negedge clk);
         exp_ctrl = '0;
         exp_bus  = '0;
         if (c == 1) begin
            exp_ctrl = {1'b1, 1'b0, !wr, wr, 1'b0};
            exp_bus  = {32'h0, addr[31:5], 5'b0};
         end else if (wr && c <= 5) begin
            exp_ctrl = 5'b01010;
            exp_bus  = wline[(c-2)*64 +: 64];
         end else if (c == done_c) begin
            exp_ctrl = 5'b00001;
         end
         check_val($sformatf("%s c%0d ctrl", nm, c),
                   {address_on_i, data_on_i, read_en_i, write_en_i, dfp_resp}, exp_ctrl);
         check_val($sformatf("%s c%0d bus", nm, c), address_data_bus_i, exp_bus);
         if (c == done_c) begin
            if (!wr) check_val($sformatf("%s rdata", nm), dfp_rdata, exp_line);
            check_val($sformatf("%s error", nm), error_o, exp_err);
            dfp_read  = 1'b0;
            dfp_write = 1'b0;
            resp_o    = 1'b0;
         end else begin
            resp_o = resp_at[c];
            if (resp_at[c] && !wr && given < 4) begin
               address_data_bus_o = rd_beat[given];
               given++;
            end else begin
               address_data_bus_o = {$urandom, $urandom};
            end
         end
      end
      @(negedge clk);
      check_val($sformatf("%s resp_pulse", nm), dfp_resp, 1'b0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [255:0] l;
      logic [31:0]  a;
      bit           wr;
      int           c;

      rst = 1'b1;
      dfp_addr = '0;
      dfp_read = 1'b0;
      dfp_write = 1'b0;
      dfp_wdata = '0;
      resp_o = 1'b0;
      address_data_bus_o = '0;
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      check_val("reset rdata", dfp_rdata, 256'h0);
      check_val("reset error", error_o, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_reset");

      clear_sched();
      for (int i = 2; i <= 5; i++) resp_at[i] = 1'b1;
      for (int i = 0; i < 4; i++) rd_beat[i] = 64'hA0 + 64'(i);
      run_txn(1'b0, 32'h0000_1234, '0, 1'b0, "rd_zero_wait");

      clear_sched();
      resp_at[9] = 1'b1;
      run_txn(1'b1, 32'h0000_0040, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 1'b0, "wr_0x40");

      clear_sched();
      resp_at[2] = 1'b1; resp_at[5] = 1'b1; resp_at[6] = 1'b1; resp_at[10] = 1'b1;
      for (int i = 0; i < 4; i++) rd_beat[i] = {$urandom, $urandom};
      run_txn(1'b0, $urandom, '0, 1'b0, "rd_gapped");

      for (int t = 0; t < 16; t++) begin
         clear_sched();
         wr = 1'($urandom_range(0, 1));
         a  = $urandom;
         l  = rand_line();
         if (wr) begin
            resp_at[6 + $urandom_range(0, 4)] = 1'b1;
         end else begin
            c = 1;
            for (int i = 0; i < 4; i++) begin
               c = c + 1 + int'($urandom_range(0, 3));
               resp_at[c] = 1'b1;
               rd_beat[i] = {$urandom, $urandom};
            end
         end
         run_txn(wr, a, l, 1'b0, $sformatf("rand%0d", t));
      end

      clear_sched();
      run_txn(1'b1, $urandom, rand_line(), 1'b1, "wr_timeout");
      clear_sched();
      for (int i = 2; i <= 5; i++) resp_at[i] = 1'b1;
      for (int i = 0; i < 4; i++) rd_beat[i] = {$urandom, $urandom};
      run_txn(1'b0, $urandom, '0, 1'b1, "rd_after_timeout");

      pulse_reset();
      check_val("rst clears error", error_o, 1'b0);
      check_val("rst clears rdata", dfp_rdata, 256'h0);
      clear_sched();
      for (int i = 2; i <= 5; i++) resp_at[i] = 1'b1;
      for (int i = 0; i < 4; i++) rd_beat[i] = {$urandom | 32'h1, $urandom};
      run_txn(1'b0, $urandom, '0, 1'b0, "rd_pre_conflict");

      dfp_read  = 1'b1;
      dfp_write = 1'b1;
      dfp_addr  = $urandom;
      @(negedge clk);
      check_val("conflict ctrl", {address_on_i, data_on_i, read_en_i, write_en_i, dfp_resp}, 5'b00001);
      check_val("conflict bus", address_data_bus_i, 64'h0);
      check_val("conflict error", error_o, 1'b1);
      check_val("conflict rdata", dfp_rdata, 256'h0);
      dfp_read  = 1'b0;
      dfp_write = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_conflict");

      pulse_reset();
      check_val("pre_spurious error", error_o, 1'b0);
      resp_o = 1'b1;
      @(negedge clk);
      resp_o = 1'b0;
      check_val("spurious error", error_o, 1'b1);
      check_idle_outputs("spurious");

      pulse_reset();
      l = rand_line();
      dfp_addr  = $urandom;
      dfp_wdata = l;
      dfp_write = 1'b1;
      repeat (4) @(negedge clk);
      check_val("abort beat2 bus", address_data_bus_i, l[128 +: 64]);
      rst = 1'b1;
      #1;
      check_idle_outputs("abort async");
      check_val("abort error", error_o, 1'b0);
      check_val("abort rdata", dfp_rdata, 256'h0);
      dfp_write = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check_idle_outputs("abort after");
      end
      clear_sched();
      resp_at[6] = 1'b1;
      run_txn(1'b1, $urandom, rand_line(), 1'b0, "wr_after_abort");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fpga_bram_ctrl.md
Name: fpga_bram_ctrl

Overview:
Controller-side master for the FPGA BRAM multiplexed address/data bus. It drives address_data_bus_i, address_on_i, data_on_i, read_en_i and write_en_i, and consumes address_data_bus_o and resp_o from the memory model. It converts 256-bit cache-line read/write requests from the cache/arbiter side into one address phase plus a 4-beat data burst. Read beats are reassembled into a line and handed back with a single-cycle response.

Parameters:
ADDRESS_DATA_WIDTH, 64, bus width; the address occupies bits [31:0], upper bits are driven 0
LINE_WIDTH, 256, cache-line width; BURST_LEN = LINE_WIDTH/ADDRESS_DATA_WIDTH = 4
TIMEOUT_CYCLES, 1024, maximum wait cycles for memory resp_o before abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
dfp_addr  in  32  line address; bits [4:0] are ignored and forced to 0 on the bus
dfp_read  in  1  read request, held high until dfp_resp
dfp_write  in  1  write request, held high until dfp_resp
dfp_wdata  in  256  write line; beat k = bits [64k+63:64k]
dfp_rdata  out  256  read line, valid while dfp_resp=1
dfp_resp  out  1  single-cycle completion pulse
address_data_bus_i  out  64  multiplexed address/write-data to memory
address_on_i  out  1  address phase qualifier
data_on_i  out  1  write-data beat qualifier
read_en_i  out  1  read command, address cycle only
write_en_i  out  1  write command, address cycle and all data cycles
address_data_bus_o  in  64  read data beat from memory
resp_o  in  1  read beat valid / write complete
error_o  out  1  sticky error flag, cleared only by rst

Behaviour:
- Reset state: all outputs 0, state IDLE, beat counter 0, timeout counter 0, dfp_rdata 0. Asserting rst mid-burst aborts immediately. No completion is sent for the aborted request.
- All bus outputs are registered.
- Default output values are 0 in any cycle not listed below.
- States: IDLE, ADDR, WDATA, WAIT_WRESP, RDATA, DONE.
- IDLE:
  - Sample the request.
  - dfp_write alone -> ADDR (write).
  - dfp_read alone -> ADDR (read).
  - Both high -> set error_o, go to DONE with no bus traffic, dfp_rdata=0.
- ADDR, exactly 1 cycle:
  - address_on_i=1, bus={32'h0, dfp_addr[31:5], 5'b0}.
  - read_en_i=1 for a read, write_en_i=1 for a write.
  - Next state: write -> WDATA, read -> RDATA.
- WDATA, exactly 4 consecutive cycles:
  - data_on_i=1, write_en_i=1, bus = beat k for k=0..3.
  - No stalls. Memory must accept one beat per cycle.
  - After beat 3 -> WAIT_WRESP.
- WAIT_WRESP: wait for resp_o=1, then go to DONE.
- RDATA:
  - resp_o may arrive starting the cycle after ADDR, on consecutive or gapped cycles.
  - Each resp_o=1 cycle captures address_data_bus_o into beat slot[counter] and increments the counter.
  - After the 4th beat -> DONE.
- DONE, 1 cycle: dfp_resp=1, dfp_rdata holds the assembled line (last value for writes), then IDLE.
  - Upstream deasserts dfp_read/dfp_write in the cycle after dfp_resp. IDLE samples fresh the next cycle.
- Latency with zero-wait memory:
  - Read: request seen in cycle 0, ADDR cycle 1, beats cycles 2-5, dfp_resp cycle 6.
  - Write: ADDR cycle 1, data cycles 2-5, resp_o cycle 6, dfp_resp cycle 7.
- Timeout:
  - The counter runs in WAIT_WRESP and in RDATA. It resets on each accepted beat.
  - On reaching TIMEOUT_CYCLES: set error_o, go to DONE. Beats not yet received read as 0.
- Spurious resp_o in IDLE, ADDR, WDATA or DONE: ignored for data, sets error_o.
- Beat counter is 2 bits and wraps only on a new request.
- read_en_i and write_en_i are never high in the same cycle. address_on_i and data_on_i are never high in the same cycle.

Decomposition:
- Package fpga_bram_pkg:
  - state enum fpga_bram_state_t {IDLE, ADDR, WDATA, WAIT_WRESP, RDATA, DONE}
  - localparams LINE_WIDTH, BURST_LEN, BEAT_IDX_W=$clog2(BURST_LEN)
- Sub-module fpga_bram_line_buffer:
  - Holds 4x64 beat storage.
  - Write-select by beat index, read-select of the wdata beat, clear on new request.
  - Instantiated once.
- FSM, counters and bus drive stay in the top module.

Test Plan:
- Zero-wait read of addr 0x0000_1234:
  - Expect bus=0x0000_0000_0000_1220 with address_on_i=1 and read_en_i=1 in cycle 1.
  - Beats 0xA0..0xA3 on cycles 2-5.
  - dfp_resp in cycle 6 with dfp_rdata={A3,A2,A1,A0}.
- Write of line {D3,D2,D1,D0} to 0x40:
  - Expect the address cycle, then data_on_i=1 with D0,D1,D2,D3 on consecutive cycles, write_en_i high for all 5 cycles.
  - resp_o after 3 idle cycles -> dfp_resp 1 cycle later, error_o=0.
- Gapped read with resp_o on cycles 2, 5, 6, 10 -> correct line assembled, dfp_resp in cycle 11.
- Memory never responds to a write -> after 1024 wait cycles error_o=1, dfp_resp pulses once, FSM returns to IDLE and the next read completes normally.
- dfp_read=dfp_write=1 -> no bus activity, error_o=1, dfp_resp next cycle. Separately, a spurious resp_o in IDLE sets error_o.
- rst asserted during WDATA beat 2 -> all outputs 0 asynchronously, no dfp_resp, and a subsequent write completes cleanly.
